// File: rtl/alu_src_b_pkg.sv
// Shared constants for the ALU B-operand stage: source indices and output-register state encoding.
package alu_src_b_pkg;

    localparam int unsigned SRC_B       = 0;
    localparam int unsigned SRC_CONST   = 1;
    localparam int unsigned SRC_SEXT    = 2;
    localparam int unsigned SRC_SEXT_SH = 3;
    localparam int unsigned SRC_EXT0    = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_src_b_stage_imm_ext.sv
// Combinational immediate extender: sign-extended immediate and its left-shifted copy.
module imm_ext #(
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SHIFT_AMT = 2
) (
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] sext,
    output logic [DATA_W-1:0] sext_sh
);

    // Signed size cast handles IMM_W == DATA_W without a zero-width replication.
    assign sext    = DATA_W'($signed(imm));
    assign sext_sh = sext << SHIFT_AMT;

endmodule

// File: rtl/alu_src_b_stage.sv
// Registered ALU B-operand selector with valid/ready handshake and illegal-select flagging.
// Optional illegal-select counter port err_cnt enabled by `ALU_SRC_B_ERR_CNT_EN.
module alu_src_b_stage
    import alu_src_b_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IMM_W     = 16,
    parameter logic [31:0] CONST_VAL = 32'd4,
    parameter int unsigned SHIFT_AMT = 2,
    parameter int unsigned NUM_EXT   = 1,
    parameter int unsigned SEL_W     = $clog2(4 + NUM_EXT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic [DATA_W-1:0]         b_data,
    input  logic [IMM_W-1:0]          imm,
    input  logic [NUM_EXT*DATA_W-1:0] ext_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_err
`ifdef ALU_SRC_B_ERR_CNT_EN
    ,
    output logic [7:0]                err_cnt
`endif
);

    localparam logic [DATA_W-1:0] CONST_W = DATA_W'(CONST_VAL);

    state_t              state;
    logic                accept;
    logic [31:0]         sel_idx;
    logic                sel_illegal;
    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W-1:0]   imm_sext;
    logic [DATA_W-1:0]   imm_sext_sh;

    imm_ext #(
        .IMM_W     (IMM_W),
        .DATA_W    (DATA_W),
        .SHIFT_AMT (SHIFT_AMT)
    ) u_imm_ext (
        .imm     (imm),
        .sext    (imm_sext),
        .sext_sh (imm_sext_sh)
    );

    assign sel_idx = 32'(sel);

    always_comb begin
        sel_data    = '0;
        sel_illegal = (sel_idx >= SRC_EXT0 + NUM_EXT);
        case (sel_idx)
            SRC_B:       sel_data = b_data;
            SRC_CONST:   sel_data = CONST_W;
            SRC_SEXT:    sel_data = imm_sext;
            SRC_SEXT_SH: sel_data = imm_sext_sh;
            default: begin
                for (int unsigned k = 0; k < NUM_EXT; k++) begin
                    if (sel_idx == SRC_EXT0 + k)
                        sel_data = ext_data[k*DATA_W +: DATA_W];
                end
            end
        endcase
    end

    assign in_ready  = (state == ST_EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_err  <= 1'b0;
        end else if (accept) begin
            state    <= ST_FULL;
            out_data <= sel_data;
            out_err  <= sel_illegal;
        end else if (out_ready) begin
            state    <= ST_EMPTY;
        end
    end

`ifdef ALU_SRC_B_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_cnt <= '0;
        else if (accept && sel_illegal && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Directed self-checking bench for alu_src_b_stage (default params and NUM_EXT=3).
module tb_alu_src_b_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready, out_valid, out_err;
    logic [2:0]  sel;
    logic [31:0] b_data;
    logic [15:0] imm;
    logic [31:0] ext_data;
    logic [31:0] out_data;

    logic        in_ready3, out_valid3, out_err3;
    logic [2:0]  sel3;
    logic [95:0] ext3;
    logic [31:0] out_data3;

`ifdef ALU_SRC_B_ERR_CNT_EN
    logic [7:0]  err_cnt, err_cnt3;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    alu_src_b_stage u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .b_data    (b_data),
        .imm       (imm),
        .ext_data  (ext_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
`ifdef ALU_SRC_B_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    alu_src_b_stage #(.NUM_EXT(3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .b_data    (b_data),
        .imm       (imm),
        .ext_data  (ext3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_data  (out_data3),
        .out_err   (out_err3)
`ifdef ALU_SRC_B_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sel = '0; sel3 = '0; b_data = '0; imm = '0; ext_data = '0;
        ext3 = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_err",   32'(out_err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
`ifdef ALU_SRC_B_ERR_CNT_EN
        chk("rst_cnt", 32'(err_cnt), 32'd0);
`endif

        // Source map, one beat per cycle with out_ready high.
        in_valid = 1'b1; out_ready = 1'b1; sel = 3'd1;
        step();
        chk("const_valid", 32'(out_valid), 32'd1);
        chk("const_data",  out_data, 32'h00000004);
        chk("const_err",   32'(out_err), 32'd0);
        sel = 3'd2; imm = 16'h8001;
        step();
        chk("sext", out_data, 32'hFFFF8001);
        sel = 3'd3;
        step();
        chk("sext_sh", out_data, 32'hFFFE0004);
        sel = 3'd4; ext_data = 32'hDEADBEEF; sel3 = 3'd6;
        step();
        chk("ext0", out_data, 32'hDEADBEEF);
        chk("ext3_ch2", out_data3, 32'hC2C2C2C2);
        sel3 = 3'd5;
        step();
        chk("ext3_ch1", out_data3, 32'hB1B1B1B1);
        chk("ext3_ch1_err", 32'(out_err3), 32'd0);
        sel3 = 3'd7;
        step();
        chk("ext3_ill_data", out_data3, 32'd0);
        chk("ext3_ill_err",  32'(out_err3), 32'd1);

        // Back-pressure: hold while inputs churn, then reload without a bubble.
        sel = 3'd0; b_data = 32'h12345678;
        step();
        out_ready = 1'b0; b_data = 32'h0; sel = 3'd1;
        #1;
        chk("bp_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            b_data = 32'(i) + 32'h100; imm = 16'(i);
            step();
            chk("bp_hold", out_data, 32'h12345678);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_stall", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1; sel = 3'd0; b_data = 32'hAAAA5555;
        #1;
        chk("bp_release", 32'(in_ready), 32'd1);
        step();
        chk("nobubble_valid", 32'(out_valid), 32'd1);
        chk("nobubble_data",  out_data, 32'hAAAA5555);
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Illegal selects on the default instance (legal codes 0..4).
        in_valid = 1'b1; sel = 3'd7;
        step();
        chk("ill7_data", out_data, 32'd0);
        chk("ill7_err",  32'(out_err), 32'd1);
        chk("ill7_valid", 32'(out_valid), 32'd1);
`ifdef ALU_SRC_B_ERR_CNT_EN
        chk("cnt_1", 32'(err_cnt), 32'd1);
`endif
        sel = 3'd5;
        step();
        chk("ill5_err", 32'(out_err), 32'd1);
`ifdef ALU_SRC_B_ERR_CNT_EN
        chk("cnt_2", 32'(err_cnt), 32'd2);
`endif
        sel = 3'd0; b_data = 32'h00000001;
        step();
        chk("legal_err_clr", 32'(out_err), 32'd0);
        chk("legal_data", out_data, 32'h00000001);
        sel = 3'd7;
        for (int i = 0; i < 300; i++) step();
`ifdef ALU_SRC_B_ERR_CNT_EN
        chk("cnt_sat", 32'(err_cnt), 32'd255);
`endif
        chk("ill_run_err", 32'(out_err), 32'd1);

        // Reset while full and stalled; reset also beats a simultaneous accept.
        sel = 3'd0; b_data = 32'h55;
        step();
        out_ready = 1'b0;
        step();
        chk("pre_rst_data", out_data, 32'h55);
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data",  out_data, 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
`ifdef ALU_SRC_B_ERR_CNT_EN
        chk("midrst_cnt", 32'(err_cnt), 32'd0);
`endif
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; b_data = 32'h77;
        step();
        chk("rst_prio_valid", 32'(out_valid), 32'd0);
        chk("rst_prio_data",  out_data, 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_src_b_stage.md
# alu_src_b_stage

Registered, parametrised successor to the ALU B-operand selector in the multicycle datapath. It chooses the ALU B operand from the B register, a configurable constant, the sign-extended immediate, the shifted sign-extended immediate, or any number of extra data channels such as memory data. The chosen operand is captured in a one-entry output register behind a valid/ready handshake. Out-of-range selector codes are detected and flagged, not left unspecified. It sits between the register/immediate fetch stage and the ALU input.

## Interface
Parameters:
- `DATA_W`, 32, operand width.
- `IMM_W`, 16, immediate width; must be ≤ `DATA_W`.
- `CONST_VAL`, 32'd4, constant source value, truncated to `DATA_W`.
- `SHIFT_AMT`, 2, left shift applied to the sign-extended immediate.
- `NUM_EXT`, 1, number of extra data channels; must be ≥ 1.
- `SEL_W`, `$clog2(4+NUM_EXT)`, selector width.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  selector and sources are valid this cycle.
- `in_ready`  out  1  stage can accept a beat.
- `sel`  in  `SEL_W`  source select.
- `b_data`  in  `DATA_W`  B register value.
- `imm`  in  `IMM_W`  raw immediate.
- `ext_data`  in  `NUM_EXT*DATA_W`  flattened extra channels; channel k occupies bits [k*DATA_W +: DATA_W].
- `out_valid`  out  1  `out_data` holds an unconsumed operand.
- `out_ready`  in  1  ALU side consumes the operand.
- `out_data`  out  `DATA_W`  registered operand.
- `out_err`  out  1  the held beat carried an illegal `sel`.
- `err_cnt`  out  8  illegal-select count; exists only with `ALU_SRC_B_ERR_CNT_EN`.

## Operation
- Source map:
  - 0 = `b_data`
  - 1 = `CONST_VAL`
  - 2 = `imm` sign-extended to `DATA_W`
  - 3 = (sign-extended `imm`) << `SHIFT_AMT`, truncated to `DATA_W`, zero fill
  - 4+k = `ext_data` channel k
- Illegal select: any `sel` ≥ 4+`NUM_EXT`. An illegal beat is still accepted. It loads `out_data` = 0 and `out_err` = 1.
- Legal beats load `out_err` = 0.
- Two-state FSM:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- `in_ready` = EMPTY or (FULL and `out_ready`).
- Accept = `in_valid` & `in_ready`. An accept loads `out_data`/`out_err` and the state becomes FULL.
- In FULL with `out_ready` and no accept, the state becomes EMPTY.
- In FULL with `out_ready` low, `out_data` and `out_err` are held stable.
- Simultaneous consume and accept in FULL: the new beat replaces the old one, the state stays FULL, and there is no bubble.
- Sources are sampled only on accept. Changes to the inputs while FULL and stalled have no effect.

## Timing
- Reset values: state EMPTY, `out_valid` 0, `out_data` 0, `out_err` 0, `err_cnt` 0.
- `in_ready` is 1 in the first cycle after reset.
- Latency: accept in cycle N gives `out_valid`/`out_data` valid in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready` stays high.
- `in_ready` is combinational from state and `out_ready`. There is no combinational path from the data inputs to any output.
- Reset asserted mid-transfer discards the held beat on that edge, with reset taking priority over an accept in the same cycle.

## Configuration
- Macro `ALU_SRC_B_ERR_CNT_EN`.
- Defined:
  - `err_cnt` port is present.
  - Increments by 1 on each accepted illegal beat.
  - Saturates at 255.
  - Cleared only by `reset`.
- Undefined:
  - Port and counter are absent.
  - `out_err` behaviour is unchanged.

## Structure
- Package `alu_src_b_pkg` holds:
  - Source index localparams `SRC_B`=0, `SRC_CONST`=1, `SRC_SEXT`=2, `SRC_SEXT_SH`=3, `SRC_EXT0`=4.
  - State encoding `ST_EMPTY`=0, `ST_FULL`=1.
- Sub-module `imm_ext`:
  - Purely combinational.
  - Parametrised by `IMM_W`, `DATA_W`, `SHIFT_AMT`.
  - Outputs both the sign-extended and the shifted-sign-extended immediate.
- Selection, FSM and output register live in the top module.

## Test plan
- Reset, then `sel`=1 with `in_valid`, `out_ready`=1 → next cycle `out_valid`=1, `out_data`=0x00000004, `out_err`=0.
- `imm`=16'h8001:
  - with `sel`=2 → `out_data`=0xFFFF8001.
  - with `sel`=3 → `out_data`=0xFFFE0004.
- `sel`=4, `ext_data`=0xDEADBEEF → `out_data`=0xDEADBEEF. With `NUM_EXT`=3, `sel`=6 selects channel 2.
- Back-pressure:
  - `b_data`=0x12345678 accepted with `sel`=0, then `out_ready`=0 for 3 cycles while the inputs change → `in_ready`=0 and `out_data` holds 0x12345678.
  - `out_ready`=1 with a new beat waiting → that beat is loaded without a bubble.
- `sel`=7 (default params) → `out_data`=0, `out_err`=1. With the macro defined, `err_cnt` goes 0→1; 300 illegal beats → `err_cnt`=255.
- `reset` asserted while FULL and stalled → next cycle `out_valid`=0, `out_data`=0, `in_ready`=1.
